// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  // Step counter must hold 0..W-1, with one spare bit of headroom.
  function automatic int unsigned count_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/carrylookahead_adder.sv
// Multi-level carry-lookahead adder, width N**LEVELS, fan-in N per lookahead group.
module carrylookahead_adder #(
  parameter int unsigned N      = 4,
  parameter int unsigned LEVELS = 2,
  localparam int unsigned W     = N ** LEVELS
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);

  // Level 0 holds per-bit generate/propagate; level l holds one entry per group of N**l bits.
  logic [W-1:0] g_lvl   [LEVELS+1];
  logic [W-1:0] p_lvl   [LEVELS+1];
  logic [W-1:0] cin_lvl [LEVELS+1];
  logic         gg, pp, c;

  // Build group G/P bottom-up, then distribute carries top-down.
  always_comb begin
    g_lvl   = '{default: '0};
    p_lvl   = '{default: '0};
    cin_lvl = '{default: '0};
    gg      = 1'b0;
    pp      = 1'b1;
    c       = 1'b0;

    for (int i = 0; i < int'(W); i++) begin
      g_lvl[0][i] = a[i] & b[i];
      p_lvl[0][i] = a[i] ^ b[i];
    end

    for (int l = 1; l <= int'(LEVELS); l++) begin
      for (int j = 0; j < int'(W / (N ** l)); j++) begin
        gg = 1'b0;
        pp = 1'b1;
        for (int k = 0; k < int'(N); k++) begin
          gg = g_lvl[l-1][j*N+k] | (p_lvl[l-1][j*N+k] & gg);
          pp = pp & p_lvl[l-1][j*N+k];
        end
        g_lvl[l][j] = gg;
        p_lvl[l][j] = pp;
      end
    end

    cin_lvl[LEVELS][0] = c_in;
    for (int l = int'(LEVELS); l >= 1; l--) begin
      for (int j = 0; j < int'(W / (N ** l)); j++) begin
        c = cin_lvl[l][j];
        for (int k = 0; k < int'(N); k++) begin
          cin_lvl[l-1][j*N+k] = c;
          c = g_lvl[l-1][j*N+k] | (p_lvl[l-1][j*N+k] & c);
        end
      end
    end

    sum   = p_lvl[0] ^ cin_lvl[0];
    c_out = g_lvl[LEVELS][0] | (p_lvl[LEVELS][0] & c_in);
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned W x W -> 2W multiplier: one shift-and-add step per clock through a
// single carry-lookahead adder, with valid/ready handshakes on both sides.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned LEVELS = 2,
  localparam int unsigned W     = N ** LEVELS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product
);

  localparam int unsigned CW = count_width(W);

  mult_state_t    state_q, state_d;
  logic [W-1:0]   acc_hi_q, acc_hi_d;
  logic [W-1:0]   acc_lo_q, acc_lo_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*W-1:0] product_q, product_d;

  logic [W-1:0]   addend;
  logic [W-1:0]   sum;
  logic           c_out;

  assign addend = acc_lo_q[0] ? mcand_q : '0;

  carrylookahead_adder #(
    .N      (N),
    .LEVELS (LEVELS)
  ) u_cla (
    .a     (acc_hi_q),
    .b     (addend),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Next-state, datapath step and handshake outputs.
  always_comb begin
    state_d   = state_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    product_d = product_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_d  = a;
          acc_lo_d = b;
          acc_hi_d = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // {c_out, sum, acc_lo[W-1:1]} is the 2W+1 bit partial product shifted right by one.
        acc_hi_d = {c_out, sum[W-1:1]};
        acc_lo_d = {sum[0], acc_lo_q[W-1:1]};
        count_d  = count_q + CW'(1);
        if (count_q == CW'(W - 1)) begin
          product_d = {acc_hi_d, acc_lo_d};
          state_d   = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random checks for shift_add_multiplier at default parameters (W = 16).
module tb_shift_add_multiplier;

  localparam int W = 16;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  int vec_count;
  int err_count;

  shift_add_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. noisy keeps in_valid high with junk operands during RUN;
  // hold is the number of DONE cycles with out_ready low before the consumer accepts.
  task automatic run_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic [2*W-1:0] exp, input int hold, input bit noisy);
    int k;
    bit run_ok;
    k = 0;
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    check_eq({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    a         = op_a;
    b         = op_b;
    out_ready = 1'b1;
    step();
    if (noisy) begin
      a = 16'd100;
      b = 16'd100;
    end else begin
      in_valid = 1'b0;
    end
    run_ok = 1'b1;
    k = 0;
    while (k < 40) begin
      if (in_ready) run_ok = 1'b0;
      step();
      k++;
      if (out_valid) break;
    end
    in_valid = 1'b0;
    check_eq({tag, " latency"}, 64'(k), 64'd16);
    check_eq({tag, " in_ready low in RUN"}, 64'(run_ok), 64'd1);
    check_eq({tag, " product"}, 64'(product), 64'(exp));
    if (hold > 0) begin
      out_ready = 1'b0;
      #3;
      for (int i = 0; i < hold; i++) begin
        step();
        check_eq({tag, " held out_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, " held product"}, 64'(product), 64'(exp));
        check_eq({tag, " held in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
    end
    step();
    check_eq({tag, " out_valid drops"}, 64'(out_valid), 64'd0);
    check_eq({tag, " in_ready back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int k;
    bit seen;
    vec_count = 0;
    err_count = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;

    step();
    step();
    rst = 1'b0;
    check_eq("reset in_ready", 64'(in_ready), 64'd1);
    check_eq("reset out_valid", 64'(out_valid), 64'd0);
    check_eq("reset product", 64'(product), 64'd0);

    run_op("3x5", 16'd3, 16'd5, 32'd15, 0, 1'b0);
    run_op("max x max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 1'b0);
    run_op("0 x max", 16'd0, 16'hFFFF, 32'd0, 0, 1'b0);
    run_op("max x 1", 16'hFFFF, 16'd1, 32'h0000FFFF, 0, 1'b0);
    run_op("255 x 255", 16'd255, 16'd255, 32'hFE01, 0, 1'b0);
    run_op("backpressure", 16'd1234, 16'd567, 32'd699678, 10, 1'b0);
    run_op("ignored input", 16'd7, 16'd9, 32'd63, 0, 1'b1);

    // Reset sampled on the 8th RUN edge discards the in-flight product.
    in_valid = 1'b1;
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midop reset in_ready", 64'(in_ready), 64'd1);
    check_eq("midop reset out_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    for (k = 0; k < 20; k++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check_eq("midop no out_valid", 64'(seen), 64'd0);
    run_op("after reset 2x3", 16'd2, 16'd3, 32'd6, 0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op("random", ra, rb, 32'(ra) * 32'(rb), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
